// File: rtl/mdu_iter_if.sv
// Request/response bundle between a requester and the iterative multiply/divide unit.
interface mdu_iter_if #(
    parameter int W = 32
);
    logic         start;
    logic [2:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] res;

    modport master (
        output start, ctl, a, b, flush,
        input  busy, done, res
    );

    modport slave (
        input  start, ctl, a, b, flush,
        output busy, done, res
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: one shift-add (multiply) or restoring
// subtract (divide) step per CALC cycle on operand magnitudes, with the sign
// fixed up on the edge that enters FIN.
//
// Handshake: start has no ready. It is taken on any edge where the FSM is not
// in CALC and flush is low (a start in FIN chains back-to-back); a start seen
// during CALC is dropped. done is a one-cycle valid for res, and res holds
// until the next done. flush aborts without a done and without touching res.
module mdu_iter #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_iter_if.slave  bus,
    output logic [1:0] dbg_state_o
);
    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W  = {{(2*W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  opb_q, opb_d;    // multiplicand / divisor magnitude
    logic [W-1:0]  hi_q, hi_d;      // product high half / partial remainder
    logic [W-1:0]  lo_q, lo_d;      // multiplier bits / dividend-quotient bits
    logic          neg_q, neg_d;    // result must be negated on entering FIN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;

    // Operand decode at acceptance
    logic         accept;
    logic         a_signed, b_signed;
    logic         a_sgn, b_sgn;
    logic [W-1:0] a_mag, b_mag;
    logic         div_zero, div_ovf, special;
    logic [W-1:0] special_res;

    // One iteration step and final result fix-up
    logic [W:0]     mul_sum, div_trial;
    logic [W-1:0]   step_hi, step_lo;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, calc_res;

    // Decode the incoming request: signedness, magnitudes and bypass cases
    always_comb begin
        accept   = bus.start && !bus.flush && (state_q != CALC);
        a_signed = (bus.ctl == 3'b001) || (bus.ctl == 3'b010) ||
                   (bus.ctl == 3'b100) || (bus.ctl == 3'b110);
        b_signed = (bus.ctl == 3'b001) || (bus.ctl == 3'b100) || (bus.ctl == 3'b110);
        a_sgn    = a_signed && bus.a[W-1];
        b_sgn    = b_signed && bus.b[W-1];
        a_mag    = a_sgn ? (~bus.a + ONE_W) : bus.a;
        b_mag    = b_sgn ? (~bus.b + ONE_W) : bus.b;
        div_zero = (bus.b == '0);
        div_ovf  = !bus.ctl[0] && (bus.a == MIN_NEG) && (bus.b == ALL_ONES);
        special  = bus.ctl[2] && (div_zero || div_ovf);
        if (div_zero) begin
            special_res = bus.ctl[1] ? bus.a : ALL_ONES;
        end else begin
            special_res = bus.ctl[1] ? '0 : MIN_NEG;
        end
    end

    // Single shift-add / restoring-subtract step and the signed result it would finish with
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_trial = {hi_q, lo_q[W-1]} - {1'b0, opb_q};
        if (!op_q[2]) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end else if (!div_trial[W]) begin
            step_hi = div_trial[W-1:0];
            step_lo = {lo_q[W-2:0], 1'b1};
        end else begin
            step_hi = {hi_q[W-2:0], lo_q[W-1]};
            step_lo = {lo_q[W-2:0], 1'b0};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? (~prod + ONE_2W) : prod;
        quo_fix  = neg_q ? (~step_lo + ONE_W) : step_lo;
        rem_fix  = neg_q ? (~step_hi + ONE_W) : step_hi;
        case (op_q)
            3'b000:                 calc_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         calc_res = quo_fix;
            default:                calc_res = rem_fix;
        endcase
    end

    // Next-state and datapath update; flush overrides everything except the captured operands
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (state_q == CALC) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = FIN;
                res_d   = calc_res;
            end
        end else if (accept) begin
            op_d  = bus.ctl;
            opb_d = b_mag;
            hi_d  = '0;
            lo_d  = a_mag;
            neg_d = (bus.ctl == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);
            if (special) begin
                state_d = FIN;
                cnt_d   = '0;
                res_d   = special_res;
            end else begin
                state_d = CALC;
                cnt_d   = CNT_INIT;
            end
        end else begin
            state_d = IDLE;
        end
        if (bus.flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            opb_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            op_q  <= op_d;
            opb_q <= opb_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign bus.busy    = (state_q == CALC);
    assign bus.done    = (state_q == FIN);
    assign bus.res     = res_q;
    assign dbg_state_o = state_q;
endmodule
